// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-side memory responder
package dmem_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [3:0] OFF_LED    = 4'h0;
    localparam logic [3:0] OFF_CYCLE  = 4'h4;
    localparam logic [3:0] OFF_TXDATA = 4'h8;
    localparam logic [3:0] OFF_TXSTAT = 4'hC;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_CNT   = 2;
    localparam int ST_OVF   = 5;
    // A RAM store is kept only when the access is naturally aligned and the size is legal
    function automatic logic storeAligned(input logic [1:0] sz, input logic [1:0] lo);
        return (sz == SZ_B) || (sz == SZ_H && !lo[0]) || (sz == SZ_W && lo == 2'b00);
    endfunction
endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// tx_fifo: byte FIFO feeding the serial transmitter, wrap-bit pointers
module tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    pushData,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic [7:0]                    headData
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign count = wrPtr - rdPtr;
    assign empty = wrPtr == rdPtr;
    assign full = count == FULL_CNT;
    assign doPop = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign headData = empty ? 8'h00 : mem[rdPtr[AW-1:0]];
    // Pointer advance and storage write; a push into a full FIFO is accepted only alongside a pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr[AW-1:0]] <= pushData;
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) rdPtr <= rdPtr + 1'b1;
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: core data-port RAM with byte-lane stores plus LED/cycle/TX MMIO window
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH      = 64,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [1:0]  size,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [31:0] ram [DEPTH];
    logic [31:0] cycleCnt, laneData, mmioRd, txStatus;
    logic [3:0] byteEn, regOff;
    logic [AW-1:0] wordIdx;
    logic [CW-1:0] fifoCount;
    logic ramHit, mmioHit, ramWe, mmioWe, txPush, txPop, statClr, overflow, fifoFull, fifoEmpty;
    assign ramHit = addr < 32'(DEPTH * 4);
    assign mmioHit = addr[31:4] == MMIO_BASE[31:4];
    assign wordIdx = addr[AW+1:2];
    assign regOff = {addr[3:2], 2'b00};
    assign ramWe = reset && we && ramHit && storeAligned(size, addr[1:0]);
    assign mmioWe = reset && we && mmioHit && size == SZ_W;
    assign txPush = mmioWe && regOff == OFF_TXDATA;
    assign statClr = mmioWe && regOff == OFF_TXSTAT;
    assign txPop = tx_valid && tx_ready;
    assign tx_valid = !fifoEmpty;
    // Byte enables and lane shift; aligned accesses make addr*8 the correct shift for every size
    always_comb begin
        byteEn = size == SZ_W ? 4'hF : size == SZ_H ? (addr[1] ? 4'hC : 4'h3) : 4'h1 << addr[1:0];
        laneData = wdata << {addr[1:0], 3'b000};
    end
    // TX status word assembled from registered FIFO state only
    always_comb begin
        txStatus = '0;
        txStatus[ST_FULL] = fifoFull;
        txStatus[ST_EMPTY] = fifoEmpty;
        txStatus[ST_CNT +: 3] = 3'(fifoCount);
        txStatus[ST_OVF] = overflow;
    end
    // Combinational load path; reflects state before this cycle's store
    always_comb begin
        mmioRd = regOff == OFF_LED ? {24'h0, led} : regOff == OFF_CYCLE ? cycleCnt : regOff == OFF_TXSTAT ? txStatus : 32'h0;
        rdata = ramHit ? ram[wordIdx] : mmioHit ? mmioRd : 32'h0;
    end
    // RAM lane writes; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (ramWe)
            for (int i = 0; i < 4; i++)
                if (byteEn[i]) ram[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
    end
    // LED register, free-running cycle counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            led <= 8'h00;
            cycleCnt <= 32'h0;
            overflow <= 1'b0;
        end else begin
            cycleCnt <= cycleCnt + 1'b1;
            if (mmioWe && regOff == OFF_LED) led <= wdata[7:0];
            if (statClr) overflow <= 1'b0;
            else if (txPush && fifoFull && !txPop) overflow <= 1'b1;
        end
    end
    tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) uFifo (
        .clk(clk),
        .reset(reset),
        .push(txPush),
        .pushData(wdata[7:0]),
        .pop(tx_ready),
        .full(fifoFull),
        .empty(fifoEmpty),
        .count(fifoCount),
        .headData(tx_data)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for loads, lane stores, MMIO and TX FIFO
module tb_dmem_responder;
    import dmem_pkg::*;
    localparam logic [31:0] A_LED = 32'hFFFF_FF00;
    localparam logic [31:0] A_CYC = 32'hFFFF_FF04;
    localparam logic [31:0] A_TXD = 32'hFFFF_FF08;
    localparam logic [31:0] A_TXS = 32'hFFFF_FF0C;
    logic clk = 0, reset = 0, we = 0, tx_ready = 0, rdChk = 0;
    logic [31:0] addr = 0, wdata = 0, rdata;
    logic [1:0] size = SZ_W;
    logic [7:0] led, tx_data;
    logic tx_valid;
    int nTests = 0, nFail = 0;
    logic [31:0] rdQ[$];
    string rdName[$];
    logic [7:0] txQ[$];
    logic [31:0] mExp;
    string mName;
    logic [7:0] tExp;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .size(size),
        .rdata(rdata), .led(led), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic rd(input string n, input logic [31:0] a, input logic [31:0] exp);
        addr = a; we = 0; size = SZ_W;
        rdQ.push_back(exp); rdName.push_back(n);
        rdChk = 1;
        @(posedge clk); #1;
        rdChk = 0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        addr = a; wdata = d; size = sz; we = 1;
        @(posedge clk); #1;
        we = 0;
    endtask

    task automatic push(input logic [7:0] b, input bit accepted);
        if (accepted) txQ.push_back(b);
        st(A_TXD, {24'h0, b}, SZ_W);
    endtask

    // Monitor: compares load data on marked cycles and every byte the consumer accepts
    always @(negedge clk) begin
        if (rdChk) begin
            nTests++;
            if (rdQ.size() == 0) begin
                nFail++;
                $display("FAIL rd-underflow: got %h expected none", rdata);
            end else begin
                mExp = rdQ.pop_front();
                mName = rdName.pop_front();
                if (rdata !== mExp) begin
                    nFail++;
                    $display("FAIL %s: got %h expected %h", mName, rdata, mExp);
                end
            end
        end
        if (tx_valid && tx_ready) begin
            nTests++;
            if (txQ.size() == 0) begin
                nFail++;
                $display("FAIL tx-unexpected: got %h expected none", tx_data);
            end else begin
                tExp = txQ.pop_front();
                if (tx_data !== tExp) begin
                    nFail++;
                    $display("FAIL tx-order: got %h expected %h", tx_data, tExp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst led", 32'(led), 0);
        chk("rst tx_valid", 32'(tx_valid), 0);
        chk("rst tx_data", 32'(tx_data), 0);
        reset = 1;
        rd("cycle first", A_CYC, 0);
        rd("status reset", A_TXS, 32'h02);
        st(32'h10, 32'hDEAD_BEEF, SZ_W);
        st(32'h12, 32'h0000_1234, SZ_H);
        st(32'h11, 32'h0000_00AA, SZ_B);
        rd("lane merge", 32'h10, 32'h1234_AAEF);
        st(32'h20, 32'h1122_3344, SZ_W);
        st(32'h23, 32'h0000_BEEF, SZ_H);
        rd("odd half dropped", 32'h20, 32'h1122_3344);
        st(32'h04, 32'h5566_7788, SZ_W);
        st(32'h06, 32'h9999_9999, SZ_W);
        st(32'h04, 32'h0000_0000, 2'b11);
        rd("misaligned word/size11", 32'h04, 32'h5566_7788);
        st(32'h8000_0000, 32'h1234_5678, SZ_W);
        rd("unmapped read", 32'h8000_0000, 0);
        st(32'h00, 32'h0BAD_C0DE, SZ_W);
        st(32'hFC, 32'hCAFE_F00D, SZ_W);
        st(32'h100, 32'hFFFF_FFFF, SZ_W);
        rd("top word", 32'hFC, 32'hCAFE_F00D);
        rd("past ram", 32'h100, 0);
        rd("word0 kept", 32'h00, 32'h0BAD_C0DE);
        st(32'h30, 32'hAAAA_5555, SZ_W);
        addr = 32'h30; wdata = 32'h5555_AAAA; size = SZ_W; we = 1;
        rdQ.push_back(32'hAAAA_5555); rdName.push_back("no write-through");
        rdChk = 1;
        @(posedge clk); #1;
        we = 0; rdChk = 0;
        rd("after store", 32'h30, 32'h5555_AAAA);
        st(A_LED, 32'hFFFF_FFA5, SZ_W);
        chk("led out", 32'(led), 32'hA5);
        rd("led read", A_LED, 32'hA5);
        st(A_LED, 32'h3C, SZ_B);
        rd("led byte ignored", A_LED, 32'hA5);
        rd("txdata reads 0", A_TXD, 0);
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        repeat (10) @(posedge clk);
        #1;
        rd("cycle 10", A_CYC, 32'd10);
        force dut.cycleCnt = 32'hFFFF_FFFE;
        #1;
        release dut.cycleCnt;
        rd("cycle forced", A_CYC, 32'hFFFF_FFFE);
        rd("cycle max", A_CYC, 32'hFFFF_FFFF);
        rd("cycle wrap", A_CYC, 32'h0);
        tx_ready = 0;
        push(8'h41, 1); push(8'h42, 1); push(8'h43, 1); push(8'h44, 1); push(8'h45, 0);
        rd("status full ovf", A_TXS, 32'h31);
        chk("tx head", 32'(tx_data), 32'h41);
        chk("tx valid full", 32'(tx_valid), 1);
        st(A_TXS, 32'h0, SZ_W);
        rd("status ovf clear", A_TXS, 32'h11);
        tx_ready = 1;
        push(8'h50, 1);
        tx_ready = 0;
        rd("status push+pop", A_TXS, 32'h11);
        tx_ready = 1;
        repeat (4) @(posedge clk);
        #1;
        tx_ready = 0;
        chk("tx drained valid", 32'(tx_valid), 0);
        chk("txq drained", 32'(txQ.size()), 0);
        rd("status drained", A_TXS, 32'h02);
        push(8'h61, 1); push(8'h62, 1); push(8'h63, 1);
        st(A_LED, 32'h5A, SZ_W);
        chk("led 5A", 32'(led), 32'h5A);
        tx_ready = 1;
        @(posedge clk); #1;
        reset = 0; addr = 32'h10; wdata = 32'hFFFF_FFFF; size = SZ_W; we = 1;
        @(posedge clk); #1;
        we = 0; reset = 1; tx_ready = 0;
        txQ.delete();
        chk("reset led", 32'(led), 0);
        chk("reset tx_valid", 32'(tx_valid), 0);
        chk("reset tx_data", 32'(tx_data), 0);
        rd("cycle after reset", A_CYC, 0);
        rd("status after reset", A_TXS, 32'h02);
        rd("ram kept in reset", 32'h10, 32'h1234_AAEF);
        chk("rdq drained", 32'(rdQ.size()), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the pipelined RISC-V core. It sits on the core's memory-stage port and answers its loads and stores. It contains a word-organised data RAM with byte-lane stores, plus a small MMIO window:
- LED output register
- free-running cycle counter
- transmit FIFO with a valid/ready output handshake toward a serial transmitter

## Interface
- `DEPTH`, 64: data RAM size in 32-bit words; power of 2.
- `MMIO_BASE`, 32'hFFFF_FF00: base address of the MMIO window.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of 2, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `addr`  in  32  byte address (core ALUResultM).
- `wdata`  in  32  store data, right-aligned (core WriteDataM).
- `we`  in  1  store strobe (core MemWriteM).
- `size`  in  2  access size (core InstrM): 00 byte, 01 half, 10 word, 11 invalid.
- `rdata`  out  32  load data (core ReadDataM); combinational.
- `led`  out  8  LED register.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts head this cycle.

## Operation
- Decode:
  - RAM hit when `addr < DEPTH*4`.
  - MMIO hit when `addr[31:4] == MMIO_BASE[31:4]`.
  - Anything else: reads return 0, writes ignored.
- RAM reads: `rdata` = full word at `addr[log2(DEPTH)+1:2]`. The core extracts and extends sub-word lanes.
- RAM stores:
  - byte: `wdata[7:0]` to lane `addr[1:0]`.
  - half: `wdata[15:0]` to lanes {`addr[1]`,0} and {`addr[1]`,1}.
  - word: all lanes.
  - Half with `addr[0]=1`, word with `addr[1:0]!=0`, or size 11: store dropped, no state change.
- MMIO registers (word access only; other sizes are ignored for writes and still read as a full word):
  - +0x0 LED: RW; bits[7:0], upper bits read 0.
  - +0x4 CYCLE: RO; 32-bit counter, +1 every cycle, wraps FFFF_FFFF→0; writes ignored.
  - +0x8 TX_DATA: WO, reads 0; a store pushes `wdata[7:0]`.
  - +0xC TX_STATUS: RO bits:
    - [0] full
    - [1] empty
    - [4:2] count
    - [5] overflow (sticky)
    - Any store to TX_STATUS clears overflow.
- FIFO:
  - Pop when `tx_valid && tx_ready`.
  - Push when the TX_DATA store arrives and the FIFO is not full, or is full with a pop in the same cycle.
  - Push while full without a pop: byte dropped, overflow set.
  - Pop while empty: no effect.
  - Simultaneous push and pop: count unchanged, pointers both advance.
- Reset (`reset` low at an edge):
  - `led`=0, counter=0, FIFO empty (`tx_valid`=0, `tx_data`=0), overflow=0.
  - RAM contents are not reset. Stores presented during reset are suppressed, including to RAM.

## Timing
- Loads: zero latency; `rdata` is combinational from `addr` and current state. It reflects state before the current cycle's store (no write-through).
- Stores take effect at the rising edge where `we`=1.
- CYCLE read in cycle n returns the value registered at edge n. The first cycle after reset release reads 0.
- A TX_DATA push at edge n makes `tx_valid`=1 from cycle n+1 if the FIFO was empty; no bypass.
- `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0.
- TX_STATUS reflects registered FIFO state. It does not see the same-cycle push or pop.

## Structure
- Shared package `dmem_pkg`:
  - size encodings (SZ_B/SZ_H/SZ_W)
  - MMIO offsets (OFF_LED, OFF_CYCLE, OFF_TXDATA, OFF_TXSTAT)
  - TX_STATUS bit positions
- Sub-module `tx_fifo`:
  - parameter `FIFO_DEPTH`, 8-bit data
  - push/full, pop/empty, count
  - pointers one bit wider than the index
- The byte-enable and lane-shift generator stays inline in `dmem_responder`.

## Test plan
- Word store 0xDEADBEEF @0x10, then half 0x1234 @0x12, then byte 0xAA @0x11 → read @0x10 = 0x1234AAEF.
- Half store @0x13 and word store @0x06 → target words unchanged; store to 0x8000_0000 → later read returns 0.
- Reset, run 10 cycles, read CYCLE → 10. Force counter to FFFF_FFFE, wait 2 cycles → reads 0.
- With `tx_ready`=0, push 0x41..0x45 → STATUS = full, count 4, overflow 1; `tx_data`=0x41. Store STATUS → overflow 0.
- FIFO full, `tx_ready`=1, push 0x50 in the same cycle → count stays 4, 0x41 popped, 0x50 last out. Drain order: 0x42, 0x43, 0x44, 0x50.
- Pull `reset` low mid-drain with LED=0x5A and a RAM store asserted → `led`=0, `tx_valid`=0, STATUS empty, RAM word unchanged.
